// File: rtl/scv_pkg.sv
// Console-level defaults for the clock-enable generator and the hold state type.
// The hold machine is compiled in only when CE_GEN_HOLD_EN is defined.
package scv_pkg;

  localparam int SCV_CPU_DIV  = 14;
  localparam int SCV_VDC_POS0 = 2;
  localparam int SCV_VDC_POS1 = 9;
  localparam int SCV_AUD_MUL  = 22;
  localparam int SCV_AUD_DIV  = 105;

  // CPU phase counter state: counting normally, or parked on the cycle boundary.
  typedef enum logic {
    CE_RUN    = 1'b0,
    CE_PARKED = 1'b1
  } ce_hold_t;

endpackage

// File: rtl/frac_ce.sv
// One fractional-rate enable channel: fires MUL times every DIV clocks with no
// long-term drift. A load restarts the phase; freeze holds the phase and mutes CE.
module frac_ce
  import scv_pkg::*;
#(
  parameter int               ACC_W   = 8,
  parameter logic [ACC_W-1:0] MUL_RST = '0,
  parameter logic [ACC_W-1:0] DIV_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             freeze,
  input  logic [ACC_W-1:0] mul_i,
  input  logic [ACC_W-1:0] div_i,
  output logic             ce
);

  logic [ACC_W-1:0] mul_q, mul_d;
  logic [ACC_W-1:0] div_q, div_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   nxt;
  logic             hit;

  // Next accumulator/CE; load beats freeze beats normal accumulation.
  always_comb begin
    mul_d = mul_q;
    div_d = div_q;
    acc_d = acc_q;
    ce_d  = 1'b0;
    nxt   = {1'b0, acc_q} + {1'b0, mul_q};
    hit   = (nxt >= {1'b0, div_q});
    if (ld) begin
      mul_d = mul_i;
      div_d = div_i;
      acc_d = '0;
    end else if (!freeze) begin
      ce_d  = hit;
      acc_d = hit ? ACC_W'(nxt - {1'b0, div_q}) : nxt[ACC_W-1:0];
    end
  end

  // Channel registers with synchronous reset to the build-time ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_q <= MUL_RST;
      div_q <= DIV_RST;
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      mul_q <= mul_d;
      div_q <= div_d;
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/ce_gen.sv
// Clock-enable generator: CPU phase strobes, VDC enable and NCH fractional
// enables from the master clock. Define CE_GEN_HOLD_EN to build the CPU hold
// machine and per-channel freeze; otherwise HOLD_REQ is ignored, HOLD_ACK = 0.
//
// Hold handshake: HOLD_REQ is a level request. HOLD_ACK rises on the edge the
// phase counter parks at CPU_DIV-1 and stays high while HOLD_REQ stays high;
// dropping HOLD_REQ releases the counter on the next edge (HOLD_ACK falls there)
// and a request withdrawn before parking has no effect. HOLD_ACK is the decoded
// state register and doubles as the FSM debug view.
module ce_gen
  import scv_pkg::*;
#(
  parameter int                   CPU_DIV        = SCV_CPU_DIV,
  parameter int                   CP2N_POS       = 0,
  parameter int                   CP1P_POS       = 2,
  parameter int                   CP1N_POS       = 4,
  parameter int                   CP2P_POS       = 6,
  parameter int                   VDC_POS0       = SCV_VDC_POS0,
  parameter int                   VDC_POS1       = SCV_VDC_POS1,
  parameter int                   NCH            = 2,
  parameter int                   ACC_W          = 8,
  parameter logic [NCH*ACC_W-1:0] FRAC_MUL       = {8'd0, 8'(SCV_AUD_MUL)},
  parameter logic [NCH*ACC_W-1:0] FRAC_DIV       = {8'd1, 8'(SCV_AUD_DIV)},
  parameter logic [NCH-1:0]       FRAC_HOLD_MASK = '0
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             HOLD_REQ,
  output logic             HOLD_ACK,
  output logic             CP1_POSEDGE,
  output logic             CP1_NEGEDGE,
  output logic             CP2_POSEDGE,
  output logic             CP2_NEGEDGE,
  output logic             VDC_CE,
  input  logic [NCH-1:0]   FRAC_LD,
  input  logic [ACC_W-1:0] FRAC_MUL_I,
  input  logic [ACC_W-1:0] FRAC_DIV_I,
  output logic [NCH-1:0]   FRAC_CE
);

  localparam int            CW   = $clog2(CPU_DIV);
  localparam logic [CW-1:0] LAST = CW'(CPU_DIV - 1);

  ce_hold_t      state_q, state_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          cp1p_q, cp1p_d, cp1n_q, cp1n_d;
  logic          cp2p_q, cp2p_d, cp2n_q, cp2n_d;
  logic          vdc_q, vdc_d;
  logic [NCH-1:0] freeze;

`ifndef CE_GEN_HOLD_EN
  logic unused_hold_req;
  assign unused_hold_req = HOLD_REQ;
`endif

  // Phase counter and hold state: park only on the last count of a CPU cycle.
  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
`ifdef CE_GEN_HOLD_EN
    case (state_q)
      CE_RUN: begin
        if (ccnt_q == LAST) begin
          if (HOLD_REQ) state_d = CE_PARKED;
          else          ccnt_d  = '0;
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
      end
      CE_PARKED: begin
        if (!HOLD_REQ) begin
          state_d = CE_RUN;
          ccnt_d  = '0;
        end
      end
      default: state_d = CE_RUN;
    endcase
`else
    ccnt_d = (ccnt_q == LAST) ? '0 : ccnt_q + 1'b1;
`endif
  end

  // Strobe decode from the current count; registered so each lags its count by one.
  always_comb begin
    cp2n_d = (ccnt_q == CW'(CP2N_POS));
    cp1p_d = (ccnt_q == CW'(CP1P_POS));
    cp1n_d = (ccnt_q == CW'(CP1N_POS));
    cp2p_d = (ccnt_q == CW'(CP2P_POS));
    vdc_d  = (ccnt_q == CW'(VDC_POS0)) || (ccnt_q == CW'(VDC_POS1));
  end

  // Counter, hold state and strobe registers.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= CE_RUN;
      ccnt_q  <= '0;
      cp1p_q  <= 1'b0;
      cp1n_q  <= 1'b0;
      cp2p_q  <= 1'b0;
      cp2n_q  <= 1'b0;
      vdc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
      cp1p_q  <= cp1p_d;
      cp1n_q  <= cp1n_d;
      cp2p_q  <= cp2p_d;
      cp2n_q  <= cp2n_d;
      vdc_q   <= vdc_d;
    end
  end

  assign HOLD_ACK    = (state_q == CE_PARKED);
  assign CP1_POSEDGE = cp1p_q;
  assign CP1_NEGEDGE = cp1n_q;
  assign CP2_POSEDGE = cp2p_q;
  assign CP2_NEGEDGE = cp2n_q;
  assign VDC_CE      = vdc_q;
  assign freeze      = FRAC_HOLD_MASK & {NCH{HOLD_ACK}};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    frac_ce #(
      .ACC_W  (ACC_W),
      .MUL_RST(FRAC_MUL[i*ACC_W +: ACC_W]),
      .DIV_RST(FRAC_DIV[i*ACC_W +: ACC_W])
    ) u_ch (
      .clk   (CLK),
      .rst   (RES),
      .ld    (FRAC_LD[i]),
      .freeze(freeze[i]),
      .mul_i (FRAC_MUL_I),
      .div_i (FRAC_DIV_I),
      .ce    (FRAC_CE[i])
    );
  end

endmodule

// File: tb/tb_ce_gen.sv
// Self-checking bench for ce_gen. A reference model built from the timing rules
// pushes each cycle's expected output word to exp_q before the edge; the word is
// popped and compared after the edge. Scenario tasks add targeted checks.
module tb_ce_gen;

  localparam int W     = 8;
  localparam int CDIV  = 14;
  localparam int P_CP2N = 0, P_CP1P = 2, P_CP1N = 4, P_CP2P = 6;
  localparam int P_V0  = 2, P_V1 = 9;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       hold_req = 1'b0;
  logic [1:0] frac_ld = 2'b00;
  logic [7:0] mul_i = 8'd0;
  logic [7:0] div_i = 8'd1;
  logic       hold_ack, cp1p, cp1n, cp2p, cp2n, vdc;
  logic [1:0] frac_ce;
  logic [W-1:0] got;
  logic [1:0] mask_v = 2'b01;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  int ph;
  bit parked;
  int n_m[2], m_m[2], d_m[2];

  always #5 clk = ~clk;

  ce_gen #(.FRAC_HOLD_MASK(2'b01)) dut (
    .CLK(clk), .RES(res), .HOLD_REQ(hold_req), .HOLD_ACK(hold_ack),
    .CP1_POSEDGE(cp1p), .CP1_NEGEDGE(cp1n), .CP2_POSEDGE(cp2p), .CP2_NEGEDGE(cp2n),
    .VDC_CE(vdc), .FRAC_LD(frac_ld), .FRAC_MUL_I(mul_i), .FRAC_DIV_I(div_i),
    .FRAC_CE(frac_ce)
  );

  assign got = {hold_ack, cp1p, cp1n, cp2p, cp2n, vdc, frac_ce};

  function automatic bit fires(int mm, int dd, int nn);
    return ((mm * nn) / dd) > ((mm * (nn - 1)) / dd);
  endfunction

  task automatic model_reset();
    ph = 0; parked = 1'b0;
    n_m[0] = 0; m_m[0] = 22; d_m[0] = 105;
    n_m[1] = 0; m_m[1] = 0;  d_m[1] = 1;
  endtask

  // one clock: predict, push, clock, pop, compare
  task automatic cycle();
    logic [W-1:0] e;
    bit par_n;
    int ph_n;
    e = '0;
    if (res) begin
      model_reset();
    end else begin
      e[6] = (ph == P_CP1P);
      e[5] = (ph == P_CP1N);
      e[4] = (ph == P_CP2P);
      e[3] = (ph == P_CP2N);
      e[2] = (ph == P_V0) || (ph == P_V1);
      par_n = parked;
      ph_n  = ph;
`ifdef CE_GEN_HOLD_EN
      if (!parked) begin
        if (ph == CDIV - 1 && hold_req) par_n = 1'b1;
        else ph_n = (ph + 1) % CDIV;
      end else if (!hold_req) begin
        par_n = 1'b0;
        ph_n  = 0;
      end
`else
      ph_n = (ph + 1) % CDIV;
`endif
      e[7] = par_n;
      for (int i = 0; i < 2; i++) begin
        if (frac_ld[i]) begin
          m_m[i] = int'(mul_i); d_m[i] = int'(div_i); n_m[i] = 0;
        end else if (!(parked && mask_v[i])) begin
          n_m[i]++;
          e[i] = fires(m_m[i], d_m[i], n_m[i]);
        end
      end
      ph = ph_n;
      parked = par_n;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL model_cycle %0d got=%b exp=%b", cyc, got, e);
    end
    cyc++;
  endtask

  task automatic do_reset();
    res = 1'b1; frac_ld = 2'b00;
    cycle();
    res = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1; hold_req = 1'b0;
    repeat (3) cycle();
    total++;
    if (got !== 8'h00) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", got, 8'h00);
    end
    res = 1'b0;
  endtask

  task automatic test_defaults(input bit req);
    int c_cp2n, c_cp1p, c_cp1n, c_cp2p, c_vdc, l_cp2n, l_cp1p, l_vdc;
    c_cp2n = 0; c_cp1p = 0; c_cp1n = 0; c_cp2p = 0; c_vdc = 0;
    l_cp2n = -100; l_cp1p = -100; l_vdc = -1;
    do_reset();
    hold_req = req;
    for (int k = 1; k <= 1400; k++) begin
      cycle();
      if (cp2n) begin c_cp2n++; l_cp2n = k; end
      if (cp1n) c_cp1n++;
      if (cp1p) begin
        c_cp1p++; total++;
        if (k - l_cp2n != 2) begin bad++; $display("FAIL cp2n_cp1p_gap got=%0d exp=2", k - l_cp2n); end
        l_cp1p = k;
      end
      if (cp2p) begin
        c_cp2p++; total++;
        if (k - l_cp1p != 4) begin bad++; $display("FAIL cp1p_cp2p_gap got=%0d exp=4", k - l_cp1p); end
      end
      if (vdc) begin
        c_vdc++;
        if (l_vdc >= 0) begin
          total++;
          if (k - l_vdc != 7) begin bad++; $display("FAIL vdc_gap got=%0d exp=7", k - l_vdc); end
        end
        l_vdc = k;
      end
      if (hold_ack !== 1'b0) begin
        total++; bad++; $display("FAIL ack_in_run got=%b exp=0", hold_ack);
      end
    end
    total += 5;
    if (c_cp2n != 100) begin bad++; $display("FAIL cnt_cp2n got=%0d exp=100", c_cp2n); end
    if (c_cp1p != 100) begin bad++; $display("FAIL cnt_cp1p got=%0d exp=100", c_cp1p); end
    if (c_cp1n != 100) begin bad++; $display("FAIL cnt_cp1n got=%0d exp=100", c_cp1n); end
    if (c_cp2p != 100) begin bad++; $display("FAIL cnt_cp2p got=%0d exp=100", c_cp2p); end
    if (c_vdc  != 200) begin bad++; $display("FAIL cnt_vdc got=%0d exp=200", c_vdc); end
    hold_req = 1'b0;
  endtask

  task automatic test_frac0();
    int cnt;
    bit prev;
    cnt = 0; prev = 1'b0;
    do_reset();
    for (int k = 1; k <= 21000; k++) begin
      cycle();
      if (frac_ce[0]) begin
        cnt++;
        if (prev) begin total++; bad++; $display("FAIL frac0_consecutive at cycle %0d", k); end
      end
      prev = frac_ce[0];
    end
    total++;
    if (cnt != 4400) begin bad++; $display("FAIL frac0_count got=%0d exp=4400", cnt); end
  endtask

  task automatic test_reload();
    int cnt;
    frac_ld = 2'b10; mul_i = 8'd1; div_i = 8'd4;
    cycle();
    frac_ld = 2'b00;
    for (int j = 1; j <= 20; j++) begin
      cycle();
      total++;
      if (frac_ce[1] !== ((j % 4) == 0)) begin
        bad++; $display("FAIL reload_1_4 edge %0d got=%b exp=%b", j, frac_ce[1], (j % 4) == 0);
      end
    end
    frac_ld = 2'b10; mul_i = 8'd0; div_i = 8'd4;
    cycle();
    frac_ld = 2'b00;
    cnt = 0;
    repeat (20) begin
      cycle();
      if (frac_ce[1]) cnt++;
    end
    total++;
    if (cnt != 0) begin bad++; $display("FAIL reload_mul0 got=%0d exp=0", cnt); end
  endtask

`ifdef CE_GEN_HOLD_EN
  task automatic test_hold();
    int c1;
    do_reset();
    frac_ld = 2'b10; mul_i = 8'd1; div_i = 8'd2;
    cycle();
    frac_ld = 2'b00;
    repeat (2) cycle();
    hold_req = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      cycle();
      if (j < 11 && hold_ack) begin total++; bad++; $display("FAIL hold_early edge %0d", j); end
    end
    total++;
    if (hold_ack !== 1'b1) begin bad++; $display("FAIL hold_ack_latency got=%b exp=1", hold_ack); end
    c1 = 0;
    repeat (50) begin
      cycle();
      total++;
      if ({got[6:2], frac_ce[0]} !== 6'b0) begin
        bad++; $display("FAIL held_quiet got=%b exp=000000", {got[6:2], frac_ce[0]});
      end
      if (frac_ce[1]) c1++;
    end
    total++;
    if (c1 != 25) begin bad++; $display("FAIL held_ch1_count got=%0d exp=25", c1); end
    hold_req = 1'b0;
    cycle();
    total++;
    if ({hold_ack, cp2n} !== 2'b00) begin bad++; $display("FAIL release_e got=%b exp=00", {hold_ack, cp2n}); end
    cycle();
    total++;
    if (cp2n !== 1'b1) begin bad++; $display("FAIL release_cp2n got=%b exp=1", cp2n); end
    repeat (14) cycle();
  endtask

  task automatic test_reset_mid_hold();
    bit seen;
    seen = 1'b0;
    hold_req = 1'b1;
    for (int j = 0; j < 20 && !seen; j++) begin
      cycle();
      seen = hold_ack;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL hold_wait got=0 exp=1"); end
    res = 1'b1; frac_ld = 2'b11; mul_i = 8'd0; div_i = 8'd4;
    cycle();
    total++;
    if (got !== 8'h00) begin bad++; $display("FAIL reset_mid_hold got=%b exp=%b", got, 8'h00); end
    res = 1'b0; frac_ld = 2'b00; hold_req = 1'b0;
    cycle();
    total++;
    if ({hold_ack, cp2n} !== 2'b01) begin bad++; $display("FAIL post_reset got=%b exp=01", {hold_ack, cp2n}); end
    repeat (20) cycle();
  endtask
`else
  task automatic test_reset_mid_cycle();
    do_reset();
    repeat (5) cycle();
    res = 1'b1; hold_req = 1'b1; frac_ld = 2'b11; mul_i = 8'd0; div_i = 8'd4;
    cycle();
    total++;
    if (got !== 8'h00) begin bad++; $display("FAIL reset_mid_cycle got=%b exp=%b", got, 8'h00); end
    res = 1'b0; frac_ld = 2'b00;
    cycle();
    total++;
    if ({hold_ack, cp2n} !== 2'b01) begin bad++; $display("FAIL post_reset got=%b exp=01", {hold_ack, cp2n}); end
    hold_req = 1'b0;
    repeat (20) cycle();
  endtask
`endif

  task automatic test_random();
    int dv;
    do_reset();
    repeat (400) begin
      if ($urandom_range(0, 15) == 0) hold_req = ~hold_req;
      frac_ld = 2'b00;
      if ($urandom_range(0, 19) == 0) begin
        dv = $urandom_range(1, 128);
        div_i = 8'(dv);
        mul_i = 8'($urandom_range(0, dv));
        frac_ld = 2'($urandom_range(1, 3));
      end
      cycle();
    end
    frac_ld = 2'b00;
    hold_req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_defaults(1'b0);
`ifndef CE_GEN_HOLD_EN
    test_defaults(1'b1);
`endif
    test_frac0();
    test_reload();
`ifdef CE_GEN_HOLD_EN
    test_hold();
    test_reset_mid_hold();
`else
    test_reset_mid_cycle();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
